router_fsm_ctrl: RTL and testbench
==================================

Name: router_fsm_ctrl

Overview:
Control state machine for the router input path. It decodes the packet header address and tracks destination FIFO status. It generates the one-hot phase strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) that sequence the router register/parity block, and the write enable and busy flags toward the FIFOs and source. It also latches the destination port for the packet in flight.

Parameters:
ADDR_W, 2, header address field width (data_in[1:0]); encodings 0..2 valid, 3 invalid
NUM_PORTS, 3, number of destination FIFOs

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source packet valid
data_in  input  ADDR_W  header address bits of current input byte
fifo_full  input  1  full flag of the currently selected FIFO
fifo_empty  input  NUM_PORTS  per-port FIFO empty flags
soft_reset  input  NUM_PORTS  per-port soft reset (read-side timeout)
parity_done  input  1  parity byte captured by register block
low_pkt_valid  input  1  pkt_valid fell during load (from register block)
detect_add  output  1  state == DECODE_ADDRESS
lfd_state  output  1  state == LOAD_FIRST_DATA
ld_state  output  1  state == LOAD_DATA
laf_state  output  1  state == LOAD_AFTER_FULL
full_state  output  1  state == FIFO_FULL_STATE
rst_int_reg  output  1  state == CHECK_PARITY_ERROR
write_enb_reg  output  1  FIFO write enable: LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
busy  output  1  source stall: high in every state except DECODE_ADDRESS and LOAD_DATA
port_sel  output  ADDR_W  latched destination address

Behaviour:
- Reset (async, resetn=0): state=DECODE_ADDRESS, port_sel=0. Outputs at reset: detect_add=1, all other strobes, write_enb_reg and busy = 0.
- Outputs are pure Moore decodes of the registered state. No output depends combinationally on inputs.
- port_sel loads data_in on a clock edge when state==DECODE_ADDRESS & pkt_valid & data_in<NUM_PORTS. Otherwise it holds.
- Transitions, evaluated on each rising edge:
  - DECODE_ADDRESS: stays here if pkt_valid=0 or the address is invalid; an invalid header (addr 3) is silently ignored.
    - pkt_valid & addr valid & fifo_empty[addr] -> LOAD_FIRST_DATA
    - pkt_valid & addr valid & ~fifo_empty[addr] -> WAIT_TILL_EMPTY
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditional, 1 cycle.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE
    - else ~pkt_valid -> LOAD_PARITY
    - else stay
  - FIFO_FULL_STATE: ~fifo_full -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS
    - else low_pkt_valid -> LOAD_PARITY
    - else -> LOAD_DATA
  - LOAD_PARITY -> CHECK_PARITY_ERROR, unconditional.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty[port_sel] -> LOAD_FIRST_DATA, else stay.
- Soft reset: soft_reset[port_sel]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS on the next edge. This overrides all other transitions. soft_reset on a non-selected port has no effect.
- Undefined state encodings recover to DECODE_ADDRESS on the next edge.
- Simultaneous fifo_full and ~pkt_valid in LOAD_DATA: full takes priority. The parity byte is captured later via LOAD_AFTER_FULL/low_pkt_valid.
- Minimum packet latency, header to CHECK_PARITY_ERROR, with no stalls: DECODE(1)+LFD(1)+LD(n)+LP(1) cycles.

Test Plan:
- Reset mid-packet: drive resetn=0 asynchronously while in LOAD_DATA -> immediate detect_add=1, busy=0, write_enb_reg=0, port_sel=0 without waiting for a clock edge.
- Normal packet: header 8'h02 with pkt_valid, fifo_empty=3'b111, 3 payload bytes, then pkt_valid=0 -> port_sel=2; states DA,LFD,LD,LD,LD,LP,CPE,DA; write_enb_reg high for LD..LP; rst_int_reg high exactly 1 cycle.
- Busy destination: header addr 1, fifo_empty=3'b101 -> WAIT_TILL_EMPTY with busy=1 for 5 cycles; set fifo_empty[1]=1 -> LFD the next cycle.
- Full during load: assert fifo_full in LOAD_DATA -> FIFO_FULL_STATE with busy=1 and write_enb_reg=0; deassert -> LAF. With low_pkt_valid=1 and parity_done=0 -> LP, then CPE, then DA.
- Soft reset: in WAIT_TILL_EMPTY with port_sel=0, pulse soft_reset=3'b010 -> no change; pulse 3'b001 -> DECODE_ADDRESS next edge.
- Invalid address: header data_in=2'b11 with pkt_valid=1 for 4 cycles -> remains in DECODE_ADDRESS, port_sel unchanged, busy=0.

Source files
------------

// File: rtl/router_fsm_ctrl.sv
// Router input-path controller: decodes the header address, sequences the
// register/parity block through one-hot phase strobes and gates FIFO writes.
module router_fsm_ctrl #(
    parameter int ADDR_W    = 2,
    parameter int NUM_PORTS = 3
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic [ADDR_W-1:0]    port_sel
);

    // Four bits leave spare encodings so a corrupted state has a defined exit.
    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        LOAD_PARITY        = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_AFTER_FULL    = 4'd5,
        WAIT_TILL_EMPTY    = 4'd6,
        CHECK_PARITY_ERROR = 4'd7
    } state_t;

    state_t state;
    state_t next_state;
    logic   addr_valid;
    logic   load_sel;

    // Loop-based select keeps the index in range for any port count.
    function automatic logic pick(input logic [NUM_PORTS-1:0] vec,
                                  input logic [ADDR_W-1:0]    idx);
        logic bit_val;
        bit_val = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx == ADDR_W'(i)) bit_val = vec[i];
        end
        return bit_val;
    endfunction

    assign addr_valid = (int'(data_in) < NUM_PORTS);
    assign load_sel   = (state == DECODE_ADDRESS) && pkt_valid && addr_valid;

    always_comb begin
        // NOTE: default first so every path assigns next_state; otherwise a latch is inferred.
        next_state = state;
        if (state != DECODE_ADDRESS && pick(soft_reset, port_sel)) begin
            next_state = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS:
                    if (load_sel)
                        next_state = pick(fifo_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA:
                    next_state = LOAD_DATA;
                LOAD_DATA:
                    if (fifo_full)       next_state = FIFO_FULL_STATE;
                    else if (!pkt_valid) next_state = LOAD_PARITY;
                FIFO_FULL_STATE:
                    if (!fifo_full) next_state = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:
                    if (parity_done)        next_state = DECODE_ADDRESS;
                    else if (low_pkt_valid) next_state = LOAD_PARITY;
                    else                    next_state = LOAD_DATA;
                LOAD_PARITY:
                    next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR:
                    next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY:
                    if (pick(fifo_empty, port_sel)) next_state = LOAD_FIRST_DATA;
                default:
                    next_state = DECODE_ADDRESS;
            endcase
        end
    end

    // Outputs are registered from next_state, so each equals a decode of state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: non-blocking for all sequential state so every register samples pre-edge values.
            state         <= DECODE_ADDRESS;
            port_sel      <= '0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= next_state;
            if (load_sel) port_sel <= data_in;
            detect_add    <= (next_state == DECODE_ADDRESS);
            lfd_state     <= (next_state == LOAD_FIRST_DATA);
            ld_state      <= (next_state == LOAD_DATA);
            laf_state     <= (next_state == LOAD_AFTER_FULL);
            full_state    <= (next_state == FIFO_FULL_STATE);
            rst_int_reg   <= (next_state == CHECK_PARITY_ERROR);
            write_enb_reg <= (next_state == LOAD_DATA) || (next_state == LOAD_PARITY) ||
                             (next_state == LOAD_AFTER_FULL);
            busy          <= !((next_state == DECODE_ADDRESS) || (next_state == LOAD_DATA));
        end
    end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed and randomized checks of router_fsm_ctrl against a phase-level
// reference model; expected strobes come from a per-phase output table.
module tb_router_fsm_ctrl;

    typedef enum {DA, LFD, LD, LP, FFS, LAF, WTE, CPE} phase_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;
    logic [1:0] port_sel;

    int         n_tests = 0;
    int         n_fail  = 0;
    phase_t     m_phase;
    logic [1:0] m_sel;

    router_fsm_ctrl #(.ADDR_W(2), .NUM_PORTS(3)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .port_sel(port_sel)
    );

    always #5 clock = ~clock;

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy, port_sel}
    function automatic logic [9:0] exp_vec(phase_t p, logic [1:0] sel);
        logic [7:0] s;
        case (p)
            DA:      s = 8'b1000_0000;
            LFD:     s = 8'b0100_0001;
            LD:      s = 8'b0010_0010;
            LAF:     s = 8'b0001_0011;
            FFS:     s = 8'b0000_1001;
            CPE:     s = 8'b0000_0101;
            LP:      s = 8'b0000_0011;
            default: s = 8'b0000_0001;
        endcase
        return {s, sel};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy, port_sel};
    endfunction

    function automatic logic bit_at(logic [2:0] v, logic [1:0] i);
        logic [3:0] ext;
        ext = {1'b0, v};
        return ext[i];
    endfunction

    task automatic check(string tag, logic [9:0] observed, logic [9:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One clock with a directed expectation; returns at the next falling edge.
    task automatic cyc_exp(string tag, phase_t want, logic [1:0] want_sel);
        @(posedge clock);
        #1;
        check(tag, obs_vec(), exp_vec(want, want_sel));
        m_phase = want;
        m_sel   = want_sel;
        @(negedge clock);
    endtask

    // One clock predicted by the reference model from the current inputs.
    task automatic model_cycle(int idx);
        phase_t     np;
        logic [1:0] ns;
        np = m_phase;
        ns = m_sel;
        if (m_phase != DA && bit_at(soft_reset, m_sel)) begin
            np = DA;
        end else begin
            case (m_phase)
                DA:  if (pkt_valid && data_in != 2'd3) begin
                         ns = data_in;
                         np = bit_at(fifo_empty, data_in) ? LFD : WTE;
                     end
                LFD: np = LD;
                LD:  np = fifo_full ? FFS : (!pkt_valid ? LP : LD);
                FFS: np = fifo_full ? FFS : LAF;
                LAF: np = parity_done ? DA : (low_pkt_valid ? LP : LD);
                LP:  np = CPE;
                CPE: np = fifo_full ? FFS : DA;
                WTE: np = bit_at(fifo_empty, m_sel) ? LFD : WTE;
                default: np = DA;
            endcase
        end
        @(posedge clock);
        #1;
        m_phase = np;
        m_sel   = ns;
        check($sformatf("rand%0d", idx), obs_vec(), exp_vec(np, ns));
        @(negedge clock);
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        m_phase = DA; m_sel = 2'd0;
        #12;
        check("reset_state", obs_vec(), exp_vec(DA, 2'd0));
        @(negedge clock);
        resetn = 1'b1;

        // Normal packet to port 2 with three payload bytes.
        pkt_valid = 1'b1; data_in = 2'd2;
        cyc_exp("np_lfd", LFD, 2'd2);
        data_in = 2'd1;
        cyc_exp("np_ld1", LD, 2'd2);
        cyc_exp("np_ld2", LD, 2'd2);
        cyc_exp("np_ld3", LD, 2'd2);
        pkt_valid = 1'b0;
        cyc_exp("np_lp", LP, 2'd2);
        cyc_exp("np_cpe", CPE, 2'd2);
        cyc_exp("np_da", DA, 2'd2);

        // Busy destination: port 1 not empty.
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
        cyc_exp("wte_enter", WTE, 2'd1);
        pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc_exp($sformatf("wte_hold%0d", i), WTE, 2'd1);
        fifo_empty = 3'b111;
        cyc_exp("wte_lfd", LFD, 2'd1);
        pkt_valid = 1'b1;
        cyc_exp("full_ld", LD, 2'd1);

        // Full during load, then low_pkt_valid route to parity.
        fifo_full = 1'b1;
        cyc_exp("full_ffs1", FFS, 2'd1);
        cyc_exp("full_ffs2", FFS, 2'd1);
        fifo_full = 1'b0;
        cyc_exp("full_laf", LAF, 2'd1);
        low_pkt_valid = 1'b1;
        cyc_exp("full_lp", LP, 2'd1);
        low_pkt_valid = 1'b0; pkt_valid = 1'b0;
        cyc_exp("full_cpe", CPE, 2'd1);
        cyc_exp("full_da", DA, 2'd1);

        // Full and end-of-packet together: full wins; parity_done exits LAF.
        pkt_valid = 1'b1; data_in = 2'd0;
        cyc_exp("prio_lfd", LFD, 2'd0);
        cyc_exp("prio_ld", LD, 2'd0);
        pkt_valid = 1'b0; fifo_full = 1'b1;
        cyc_exp("prio_ffs", FFS, 2'd0);
        fifo_full = 1'b0;
        cyc_exp("prio_laf", LAF, 2'd0);
        parity_done = 1'b1;
        cyc_exp("prio_da", DA, 2'd0);
        parity_done = 1'b0;

        // Soft reset on the selected port only.
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b110;
        cyc_exp("sr_wte", WTE, 2'd0);
        pkt_valid = 1'b0; soft_reset = 3'b010;
        cyc_exp("sr_other", WTE, 2'd0);
        soft_reset = 3'b001;
        cyc_exp("sr_hit", DA, 2'd0);
        soft_reset = 3'b000; fifo_empty = 3'b111;

        // Invalid header address is ignored.
        pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 4; i++) cyc_exp($sformatf("bad_addr%0d", i), DA, 2'd0);

        // Asynchronous reset in the middle of a packet.
        data_in = 2'd2;
        cyc_exp("rst_lfd", LFD, 2'd2);
        cyc_exp("rst_ld", LD, 2'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async", obs_vec(), exp_vec(DA, 2'd0));
        m_phase = DA; m_sel = 2'd0;
        @(negedge clock);
        resetn = 1'b1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            pkt_valid     = ($urandom_range(3, 0) != 0);
            data_in       = 2'($urandom_range(3, 0));
            fifo_full     = ($urandom_range(3, 0) == 0);
            fifo_empty    = 3'($urandom_range(7, 0));
            soft_reset    = {($urandom_range(15, 0) == 0), ($urandom_range(15, 0) == 0),
                             ($urandom_range(15, 0) == 0)};
            parity_done   = ($urandom_range(3, 0) == 0);
            low_pkt_valid = ($urandom_range(1, 0) == 0);
            model_cycle(i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
